// File: rtl/mul_pkg.sv
// Shared definitions for the repeated-addition multiplier: controller state encoding
// and default watchdog sizing.
package mul_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_MULT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int MAX_ITER_DEF = 65536;
    localparam int CNT_W_DEF    = 17;

endpackage

// File: rtl/mul_iter_cnt.sv
// Iteration counter for the multiplier watchdog: sync clear, count enable and a
// terminal flag raised when the count reaches MAX_ITER-1.
module mul_iter_cnt
    import mul_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic term
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign term = (count == CNT_W'(MAX_ITER - 1));

endmodule

// File: rtl/mul_controller.sv
// Control FSM for the repeated-addition multiplier: operand handshake, P clear,
// one add/decrement strobe per iteration until eqz, with an iteration watchdog.
module mul_controller
    import mul_pkg::*;
#(
    parameter int MAX_ITER = MAX_ITER_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic in_valid,
    output logic in_ready,
    input  logic eqz,
    output logic lda,
    output logic ldb,
    output logic clrp,
    output logic ldp,
    output logic decb,
    output logic busy,
    output logic done,
    output logic err
);

    state_t state;
    logic   err_q;
    logic   term;

    mul_iter_cnt #(
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (ldb),
        .en   (ldp),
        .term (term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            err_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    err_q <= 1'b0;
                    if (start) state <= S_LOAD_A;
                end
                S_LOAD_A: if (in_valid) state <= S_LOAD_B;
                S_LOAD_B: if (in_valid) state <= S_MULT;
                S_MULT: begin
                    if (eqz) begin
                        state <= S_DONE;
                    end else if (term) begin
                        // Watchdog abort: flag the error for the DONE cycle.
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Mealy decode: strobes follow in_valid/eqz in the same cycle; reset forces all low.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        in_ready = 1'b0;
        lda      = 1'b0;
        ldb      = 1'b0;
        clrp     = 1'b0;
        ldp      = 1'b0;
        decb     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        if (!rst) begin
            unique case (state)
                S_IDLE: ;
                S_LOAD_A: begin
                    busy     = 1'b1;
                    in_ready = 1'b1;
                    lda      = in_valid;
                end
                S_LOAD_B: begin
                    busy     = 1'b1;
                    in_ready = 1'b1;
                    ldb      = in_valid;
                    clrp     = in_valid;
                end
                S_MULT: begin
                    busy = 1'b1;
                    ldp  = !eqz && !term;
                    decb = !eqz && !term;
                end
                S_DONE: begin
                    busy = 1'b1;
                    done = 1'b1;
                    err  = err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_controller.sv
// Directed bench for mul_controller with a behavioural datapath model (A, B counter, P),
// plus a second controller instance with a short watchdog and eqz tied low.
module tb_mul_controller;

    localparam logic [8:0] RDY  = 9'h100;
    localparam logic [8:0] LDA  = 9'h080;
    localparam logic [8:0] LDB  = 9'h040;
    localparam logic [8:0] CLRP = 9'h020;
    localparam logic [8:0] LDP  = 9'h010;
    localparam logic [8:0] DECB = 9'h008;
    localparam logic [8:0] BSY  = 9'h004;
    localparam logic [8:0] DN   = 9'h002;
    localparam logic [8:0] ER   = 9'h001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic [15:0] data_in = 16'd0;
    logic in_ready, eqz, lda, ldb, clrp, ldp, decb, busy, done, err;

    logic start2 = 1'b0;
    logic valid2 = 1'b0;
    logic eqz2 = 1'b0;
    logic in_ready2, lda2, ldb2, clrp2, ldp2, decb2, busy2, done2, err2;

    logic [15:0] a_r = 16'd0;
    logic [15:0] b_r = 16'd0;
    logic [31:0] p = 32'd0;

    logic [8:0] outs, outs2;
    logic sel = 1'b0;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul_controller u_dut (
        .clk (clk), .rst (rst), .start (start), .in_valid (in_valid), .in_ready (in_ready),
        .eqz (eqz), .lda (lda), .ldb (ldb), .clrp (clrp), .ldp (ldp), .decb (decb),
        .busy (busy), .done (done), .err (err)
    );

    mul_controller #(.MAX_ITER (8), .CNT_W (4)) u_wd (
        .clk (clk), .rst (rst), .start (start2), .in_valid (valid2), .in_ready (in_ready2),
        .eqz (eqz2), .lda (lda2), .ldb (ldb2), .clrp (clrp2), .ldp (ldp2), .decb (decb2),
        .busy (busy2), .done (done2), .err (err2)
    );

    // Behavioural datapath: not reset by rst, P cleared only by clrp.
    always @(posedge clk) begin
        if (lda) a_r <= data_in;
        if (ldb) b_r <= data_in;
        else if (decb) b_r <= b_r - 16'd1;
        if (clrp) p <= 32'd0;
        else if (ldp) p <= p + {16'd0, a_r};
    end
    assign eqz = (b_r == 16'd0);

    assign outs  = {in_ready, lda, ldb, clrp, ldp, decb, busy, done, err};
    assign outs2 = {in_ready2, lda2, ldb2, clrp2, ldp2, decb2, busy2, done2, err2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sample outputs mid-cycle, then step to just after the next rising edge.
    task automatic cyc(input string tag, input logic [8:0] exp);
        @(negedge clk);
        chk(tag, {23'd0, (sel ? outs2 : outs)}, {23'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string pre, input logic [15:0] a, input logic [15:0] b,
                          input int sa, input int sb, input logic [31:0] pexp);
        start = 1'b1; in_valid = 1'b0; data_in = 16'hdead;
        cyc({pre, " idle"}, 9'h000);
        start = 1'b0;
        for (int i = 0; i < sa; i++) cyc({pre, " stall_a"}, RDY | BSY);
        in_valid = 1'b1; data_in = a;
        cyc({pre, " load_a"}, RDY | LDA | BSY);
        in_valid = 1'b0; data_in = 16'hbeef;
        for (int i = 0; i < sb; i++) cyc({pre, " stall_b"}, RDY | BSY);
        in_valid = 1'b1; data_in = b;
        cyc({pre, " load_b"}, RDY | LDB | CLRP | BSY);
        in_valid = 1'b0; data_in = 16'hdead;
        for (int i = 0; i < int'(b); i++) cyc({pre, " mult"}, LDP | DECB | BSY);
        cyc({pre, " mult_eqz"}, BSY);
        cyc({pre, " done"}, BSY | DN);
        cyc({pre, " back_idle"}, 9'h000);
        chk({pre, " product"}, p, pexp);
    endtask

    initial begin
        // Reset: outputs forced low even with start/in_valid high.
        start = 1'b1; in_valid = 1'b1;
        cyc("reset0", 9'h000);
        cyc("reset1", 9'h000);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        cyc("idle_after_reset", 9'h000);

        run_op("t1 5x3", 16'd5, 16'd3, 0, 0, 32'd15);
        run_op("t2 7x0", 16'd7, 16'd0, 0, 0, 32'd0);
        run_op("t2 0x4", 16'd0, 16'd4, 0, 0, 32'd0);
        run_op("t3 12x11", 16'd12, 16'd11, 4, 2, 32'd132);

        // Reset on the second MULT cycle of 3x9.
        start = 1'b1;
        cyc("t5 idle", 9'h000);
        start = 1'b0; in_valid = 1'b1; data_in = 16'd3;
        cyc("t5 load_a", RDY | LDA | BSY);
        data_in = 16'd9;
        cyc("t5 load_b", RDY | LDB | CLRP | BSY);
        in_valid = 1'b0;
        cyc("t5 mult1", LDP | DECB | BSY);
        rst = 1'b1;
        cyc("t5 reset_cycle", 9'h000);
        rst = 1'b0;
        cyc("t5 idle_after", 9'h000);
        chk("t5 p_stale", p, 32'd3);
        run_op("t5 2x6", 16'd2, 16'd6, 0, 0, 32'd12);

        // start ignored during MULT; held through DONE -> one IDLE cycle then LOAD_A.
        start = 1'b1;
        cyc("t6 idle", 9'h000);
        start = 1'b0; in_valid = 1'b1; data_in = 16'd4;
        cyc("t6 load_a", RDY | LDA | BSY);
        data_in = 16'd5;
        cyc("t6 load_b", RDY | LDB | CLRP | BSY);
        in_valid = 1'b0;
        cyc("t6 mult1", LDP | DECB | BSY);
        start = 1'b1;
        cyc("t6 mult2", LDP | DECB | BSY);
        start = 1'b0;
        for (int i = 0; i < 3; i++) cyc("t6 mult", LDP | DECB | BSY);
        start = 1'b1;
        cyc("t6 mult_eqz", BSY);
        cyc("t6 done", BSY | DN);
        cyc("t6 one_idle", 9'h000);
        chk("t6 product", p, 32'd20);
        start = 1'b0;
        cyc("t6 restart_load_a", RDY | BSY);
        in_valid = 1'b1; data_in = 16'd1;
        cyc("t6b load_a", RDY | LDA | BSY);
        cyc("t6b load_b", RDY | LDB | CLRP | BSY);
        in_valid = 1'b0;
        cyc("t6b mult", LDP | DECB | BSY);
        cyc("t6b mult_eqz", BSY);
        cyc("t6b done", BSY | DN);
        cyc("t6b idle", 9'h000);
        chk("t6b product", p, 32'd1);

        // Watchdog instance: MAX_ITER=8, eqz stuck low -> 7 strobes, then done+err.
        sel = 1'b1;
        start2 = 1'b1;
        cyc("t4 idle", 9'h000);
        start2 = 1'b0; valid2 = 1'b1;
        cyc("t4 load_a", RDY | LDA | BSY);
        cyc("t4 load_b", RDY | LDB | CLRP | BSY);
        valid2 = 1'b0;
        for (int i = 0; i < 7; i++) cyc("t4 mult", LDP | DECB | BSY);
        cyc("t4 watchdog", BSY);
        cyc("t4 done_err", BSY | DN | ER);
        cyc("t4 idle_after", 9'h000);
        start2 = 1'b1;
        cyc("t4 idle_again", 9'h000);
        start2 = 1'b0;
        cyc("t4 err_cleared_load_a", RDY | BSY);
        sel = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
